adc_decimating_averager: RTL and testbench
==========================================

Name: adc_decimating_averager

Overview:
- Sits directly downstream of the ADC channel router and consumes one 14-bit channel stream (RX or TX word, sample in bits [13:0], zero-padded above).
- Sums 2^LOG2_DEC consecutive two's-complement samples and emits their mean as a sign-extended 32-bit AXI-Stream word.
- The output is held until downstream accepts it.
- Drives slow-rate monitoring and readback paths, where a 125 MHz raw stream is too fast.

Parameters:
- DATA_W, 14: input sample width; the sample is two's complement with its sign at bit DATA_W-1.
- LOG2_DEC, 6: log2 of the decimation ratio N; legal range 1..16.
- OVR_W, 16: width of the overrun counter.

Ports:
- clk  in  1  sample clock, 125 MHz.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  accumulate enable; when low, samples are ignored and state is held.
- clear  in  1  synchronous; discards the partial sum and clears the overrun status.
- S_AXIS_tdata  in  32  bits [DATA_W-1:0] are the sample; upper bits are ignored.
- S_AXIS_tvalid  in  1  sample qualifier.
- M_AXIS_tdata  out  32  mean of the block, sign-extended.
- M_AXIS_tvalid  out  1  result pending.
- M_AXIS_tready  in  1  downstream accept.
- overrun  out  1  sticky; a completed result was dropped.
- overrun_cnt  out  OVR_W  saturating count of dropped results.

Behaviour:
- Reset (asynchronous):
  - All outputs are 0: M_AXIS_tdata, M_AXIS_tvalid, overrun and overrun_cnt.
  - The accumulator, the sample counter and the state are 0.
- Sample accept: a sample is taken on any clk edge where S_AXIS_tvalid && en && !clear. There is no S_AXIS_tready; the block accepts at line rate.
- Accumulator and counter:
  - The accumulator is DATA_W+LOG2_DEC bits, signed; it cannot overflow.
  - The counter runs 0..N-1.
- States:
  - ACC: the normal state.
  - HOLD: entered with M_AXIS_tvalid=1 while downstream is stalled. HOLD is encoded by M_AXIS_tvalid; accumulation continues in both states.
- Block completion: on the accepted sample where the counter equals N-1:
  - result = (acc + sample) >>> LOG2_DEC, an arithmetic shift that truncates toward minus infinity.
  - The result is sign-extended to 32 bits.
  - The accumulator and counter return to 0 on the same edge.
- Output timing:
  - M_AXIS_tdata/M_AXIS_tvalid update on the edge that takes the Nth sample.
  - Latency from the Nth sample to tvalid is 1 cycle.
- Handshake:
  - The transfer occurs on M_AXIS_tvalid && M_AXIS_tready.
  - tdata is stable while tvalid=1 and tready=0.
  - tvalid drops after the transfer unless a new result loads on the same edge.
- Simultaneous completion and transfer: the old word transfers, the new word loads, and tvalid stays 1. No overrun.
- Completion while stalled (tvalid=1, tready=0):
  - The new result is dropped and the old word is kept.
  - overrun is set and overrun_cnt increments, saturating at 2^OVR_W-1.
- en low mid-block: the accumulator and counter hold; the partial sum resumes when en returns.
- clear:
  - Zeroes the accumulator, the counter, overrun and overrun_cnt.
  - A pending output word is not affected.
  - clear has priority over a same-cycle sample.
- rst mid-block: the partial sum and the pending word are lost immediately; the first result after reset needs N fresh samples.

Optional Feature:
- Macro: ADC_AVG_FULLRES_EN.
- Defined: M_AXIS_tdata carries the full unshifted sum (acc + sample), sign-extended to 32 bits. This requires DATA_W+LOG2_DEC <= 32; otherwise elaboration fails with an error.
- Undefined: the mean is output as described in Behaviour.

Decomposition:
- Shared package adc_avg_pkg:
  - localparam ADC_SAMPLE_W=14.
  - localparam AXIS_W=32.
  - A function for sign-extension from DATA_W to AXIS_W.
- One natural sub-module, axis_hold_reg: the output register with tvalid/tready handling and drop-on-full detection, which reports "dropped" back to the parent.
- The accumulator, counter and overrun logic remain in the parent.

Test Plan (LOG2_DEC=2, so N=4; en=1 and tready=1 unless stated):
- Basic mean: samples 100, 200, 300, 400 -> one cycle later tvalid=1 and tdata=0x000000FA (250).
- Negative samples: 0x3FFF ×4 (-1 each) -> tdata=0xFFFFFFFF. Samples 0x2000 ×4 (-8192) -> tdata=0xFFFFE000.
- Truncation: samples 1, 0, 0, 0 -> tdata=0. Samples -1, 0, 0, 0 -> tdata=0xFFFFFFFF (floor).
- Backpressure: tready=0 for 8 samples of value 10 -> tvalid=1, tdata=10, overrun=1, overrun_cnt=1. Then tready=1 for one cycle -> transfer, then tvalid=0. Then clear -> overrun=0, overrun_cnt=0.
- Pause and clear:
  - Samples 4, 4; en=0 for 5 cycles; then 4, 4 -> tdata=4.
  - Samples 4, 4; clear; then 8 ×4 -> tdata=8.
- Async reset mid-block: samples 7, 7, then rst pulsed between clock edges -> all outputs read 0 immediately. Then 2 ×4 -> tdata=2.

Source files
------------

// File: rtl/adc_avg_pkg.sv
// ---------------------------------------------------------------------------
// adc_avg_pkg
// Shared constants and helpers for the ADC decimating averager.
//   ADC_SAMPLE_W : native sample width of the ADC channel stream
//   AXIS_W       : AXI-Stream word width used on both ports
//   sext_to_axis : sign-extend the low w bits of a word to AXIS_W bits
// ---------------------------------------------------------------------------
package adc_avg_pkg;

  localparam int ADC_SAMPLE_W = 14;
  localparam int AXIS_W       = 32;

  // Bits at and above position w are replaced by bit w-1.
  // w must be in 1..AXIS_W.
  function automatic logic [AXIS_W-1:0] sext_to_axis(input logic [AXIS_W-1:0] v,
                                                     input int                w);
    logic [AXIS_W-1:0] r;
    for (int i = 0; i < AXIS_W; i++) begin
      r[i] = (i < w) ? v[i] : v[w-1];
    end
    return r;
  endfunction

endpackage

// File: rtl/adc_decimating_averager_axis_hold_reg.sv
// ---------------------------------------------------------------------------
// axis_hold_reg
// Single-entry AXI-Stream output register. A word offered on load_i is
// captured when the register is empty or is being emptied on the same edge.
// If the register is full and stalled, the offered word is discarded, the
// held word is kept, and dropped_o is raised for that cycle.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   load_i     : a new word is offered this cycle
//   data_i     : the offered word
//   ready_i    : downstream accept
//   data_o     : held word (stable while valid_o=1 and ready_i=0)
//   valid_o    : a word is pending
//   dropped_o  : combinational, the offered word is discarded this cycle
// ---------------------------------------------------------------------------
module axis_hold_reg #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  input  logic         ready_i,
  output logic [W-1:0] data_o,
  output logic         valid_o,
  output logic         dropped_o
);

  logic [W-1:0] data_q, data_d;
  logic         valid_q, valid_d;
  logic         can_load;

  // The register frees up on this edge if it is empty or transferring.
  assign can_load  = !valid_q || ready_i;
  assign dropped_o = load_i && !can_load;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (load_i && can_load) begin
      data_d  = data_i;
      valid_d = 1'b1;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/adc_decimating_averager.sv
// ---------------------------------------------------------------------------
// adc_decimating_averager
// Sums 2^LOG2_DEC consecutive signed samples and emits their floor mean as a
// sign-extended 32-bit AXI-Stream word. The output word is held until
// downstream accepts it; a block completing while the output is stalled is
// dropped and counted.
// Build option: define ADC_AVG_FULLRES_EN to output the full unshifted block
// sum instead of the mean (requires DATA_W+LOG2_DEC <= 32).
// Ports:
//   clk, rst       : clock, asynchronous active-high reset
//   en             : accumulate enable (state holds while low)
//   clear          : synchronous clear of partial sum and overrun status
//   S_AXIS_tdata   : sample in bits [DATA_W-1:0], upper bits ignored
//   S_AXIS_tvalid  : sample qualifier (no backpressure on input)
//   M_AXIS_tdata   : block result, sign-extended
//   M_AXIS_tvalid  : result pending
//   M_AXIS_tready  : downstream accept
//   overrun        : sticky, a completed result was dropped
//   overrun_cnt    : saturating count of dropped results
// ---------------------------------------------------------------------------
module adc_decimating_averager
  import adc_avg_pkg::*;
#(
  parameter int DATA_W   = ADC_SAMPLE_W,
  parameter int LOG2_DEC = 6,
  parameter int OVR_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clear,
  input  logic [AXIS_W-1:0] S_AXIS_tdata,
  input  logic              S_AXIS_tvalid,
  output logic [AXIS_W-1:0] M_AXIS_tdata,
  output logic              M_AXIS_tvalid,
  input  logic              M_AXIS_tready,
  output logic              overrun,
  output logic [OVR_W-1:0]  overrun_cnt
);

  localparam int ACC_W = DATA_W + LOG2_DEC;

  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic        [LOG2_DEC-1:0] cnt_q, cnt_d;
  logic                       overrun_q, overrun_d;
  logic        [OVR_W-1:0]    ovr_cnt_q, ovr_cnt_d;

  logic signed [ACC_W-1:0]    sample_ext;
  logic signed [ACC_W-1:0]    sum;
  logic                       accept;
  logic                       block_done;
  logic                       dropped;
  logic        [AXIS_W-1:0]   result_word;
  logic                       unused_tdata;

  assign unused_tdata = ^S_AXIS_tdata[AXIS_W-1:DATA_W];

  assign accept     = S_AXIS_tvalid && en && !clear;
  // Counter width is LOG2_DEC, so N-1 is the all-ones value.
  assign block_done = accept && (&cnt_q);
  assign sample_ext = {{LOG2_DEC{S_AXIS_tdata[DATA_W-1]}}, S_AXIS_tdata[DATA_W-1:0]};
  assign sum        = acc_q + sample_ext;

`ifdef ADC_AVG_FULLRES_EN
  if (ACC_W > AXIS_W) begin : g_fullres_width_check
    $error("ADC_AVG_FULLRES_EN needs DATA_W+LOG2_DEC <= 32");
  end
  assign result_word = sext_to_axis(AXIS_W'(unsigned'(sum)), ACC_W);
`else
  // Dropping the low LOG2_DEC bits of a two's-complement sum is the
  // arithmetic shift, i.e. floor division by N; the remaining DATA_W bits
  // always hold the full mean.
  assign result_word = sext_to_axis(AXIS_W'(sum[ACC_W-1:LOG2_DEC]), DATA_W);
`endif

  always_comb begin
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    overrun_d = overrun_q;
    ovr_cnt_d = ovr_cnt_q;
    if (clear) begin
      acc_d     = '0;
      cnt_d     = '0;
      overrun_d = 1'b0;
      ovr_cnt_d = '0;
    end else begin
      if (block_done) begin
        acc_d = '0;
        cnt_d = '0;
      end else if (accept) begin
        acc_d = sum;
        cnt_d = cnt_q + 1'b1;
      end
      // dropped implies block_done, which already excludes clear.
      if (dropped) begin
        overrun_d = 1'b1;
        if (!(&ovr_cnt_q)) begin
          ovr_cnt_d = ovr_cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q     <= '0;
      cnt_q     <= '0;
      overrun_q <= 1'b0;
      ovr_cnt_q <= '0;
    end else begin
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      overrun_q <= overrun_d;
      ovr_cnt_q <= ovr_cnt_d;
    end
  end

  // HOLD is simply M_AXIS_tvalid=1 inside the output register.
  axis_hold_reg #(
    .W (AXIS_W)
  ) u_out (
    .clk       (clk),
    .rst       (rst),
    .load_i    (block_done),
    .data_i    (result_word),
    .ready_i   (M_AXIS_tready),
    .data_o    (M_AXIS_tdata),
    .valid_o   (M_AXIS_tvalid),
    .dropped_o (dropped)
  );

  assign overrun     = overrun_q;
  assign overrun_cnt = ovr_cnt_q;

endmodule

// File: tb/tb_adc_decimating_averager.sv
// ---------------------------------------------------------------------------
// tb_adc_decimating_averager
// Self-checking bench for adc_decimating_averager with N=4 and a 4-bit
// overrun counter so saturation is reachable. A queue-based block model
// computes expected outputs with integer floor division.
// ---------------------------------------------------------------------------
module tb_adc_decimating_averager;

  localparam int DATA_W   = 14;
  localparam int LOG2_DEC = 2;
  localparam int N        = 1 << LOG2_DEC;
  localparam int OVR_W    = 4;
  localparam int OVR_MAX  = (1 << OVR_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0;
  logic             clear = 1'b0;
  logic [31:0]      S_AXIS_tdata = '0;
  logic             S_AXIS_tvalid = 1'b0;
  logic [31:0]      M_AXIS_tdata;
  logic             M_AXIS_tvalid;
  logic             M_AXIS_tready = 1'b1;
  logic             overrun;
  logic [OVR_W-1:0] overrun_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  int          blk[$];
  logic [31:0] m_data;
  bit          m_valid;
  bit          m_ovr;
  int          m_cnt;

  adc_decimating_averager #(
    .DATA_W   (DATA_W),
    .LOG2_DEC (LOG2_DEC),
    .OVR_W    (OVR_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .clear         (clear),
    .S_AXIS_tdata  (S_AXIS_tdata),
    .S_AXIS_tvalid (S_AXIS_tvalid),
    .M_AXIS_tdata  (M_AXIS_tdata),
    .M_AXIS_tvalid (M_AXIS_tvalid),
    .M_AXIS_tready (M_AXIS_tready),
    .overrun       (overrun),
    .overrun_cnt   (overrun_cnt)
  );

  always #5 clk = ~clk;

  function automatic int to_sample(input logic [31:0] d);
    int v;
    v = int'(d[DATA_W-1:0]);
    if (v >= (1 << (DATA_W - 1))) v = v - (1 << DATA_W);
    return v;
  endfunction

  function automatic int floor_mean(input int s);
    if (s >= 0) return s / N;
    return -((-s + N - 1) / N);
  endfunction

  task automatic model_reset();
    blk.delete();
    m_data  = '0;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
    m_cnt   = 0;
  endtask

  task automatic model_edge(input bit tv, input logic [31:0] d, input bit e,
                            input bit c, input bit r);
    bit          take;
    bit          done;
    int          s;
    logic [31:0] res;
    take = tv && e && !c;
    done = 1'b0;
    res  = '0;
    if (c) begin
      blk.delete();
      m_ovr = 1'b0;
      m_cnt = 0;
    end
    if (take) begin
      blk.push_back(to_sample(d));
      if (blk.size() == N) begin
        s = 0;
        foreach (blk[k]) s += blk[k];
        res  = floor_mean(s);
        done = 1'b1;
        blk.delete();
      end
    end
    if (done) begin
      if (m_valid && !r) begin
        m_ovr = 1'b1;
        if (m_cnt < OVR_MAX) m_cnt++;
      end else begin
        m_data  = res;
        m_valid = 1'b1;
      end
    end else if (m_valid && r) begin
      m_valid = 1'b0;
    end
  endtask

  // Drive one cycle of inputs, advance the model at the edge, settle.
  task automatic step(input bit tv, input logic [31:0] d, input bit e,
                      input bit c, input bit r);
    S_AXIS_tvalid = tv;
    S_AXIS_tdata  = d;
    en            = e;
    clear         = c;
    M_AXIS_tready = r;
    @(posedge clk);
    model_edge(tv, d, e, c, r);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (M_AXIS_tdata !== 32'h0) begin n_bad++; $display("FAIL reset_tdata got=%h exp=%h", M_AXIS_tdata, 32'h0); end
    n_cmp++; if (M_AXIS_tvalid !== 1'b0) begin n_bad++; $display("FAIL reset_tvalid got=%b exp=0", M_AXIS_tvalid); end
    n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
    n_cmp++; if (overrun_cnt !== 4'h0) begin n_bad++; $display("FAIL reset_ovr_cnt got=%0d exp=0", overrun_cnt); end
    rst = 1'b0;
    $display("reset: outputs tdata=%h tvalid=%b overrun=%b cnt=%0d", M_AXIS_tdata, M_AXIS_tvalid, overrun, overrun_cnt);
  endtask

  task automatic test_basic();
    step(0, 0, 1, 1, 1);
    step(1, 100, 1, 0, 1);
    step(1, 200, 1, 0, 1);
    step(1, 300, 1, 0, 1);
    n_cmp++; if (M_AXIS_tvalid !== 1'b0) begin n_bad++; $display("FAIL basic_early_valid got=%b exp=0", M_AXIS_tvalid); end
    step(1, 400, 1, 0, 1);
    n_cmp++; if (M_AXIS_tvalid !== 1'b1) begin n_bad++; $display("FAIL basic_valid got=%b exp=1", M_AXIS_tvalid); end
    n_cmp++; if (M_AXIS_tdata !== 32'h0000_00FA) begin n_bad++; $display("FAIL basic_data got=%h exp=%h", M_AXIS_tdata, 32'h0000_00FA); end
    $display("basic: word %h", M_AXIS_tdata);
    step(0, 0, 1, 0, 1);
    n_cmp++; if (M_AXIS_tvalid !== 1'b0) begin n_bad++; $display("FAIL basic_drop_valid got=%b exp=0", M_AXIS_tvalid); end
  endtask

  task automatic test_negative();
    step(0, 0, 1, 1, 1);
    repeat (N) step(1, 32'h3FFF, 1, 0, 1);
    n_cmp++; if (M_AXIS_tdata !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL neg_minus1 got=%h exp=%h", M_AXIS_tdata, 32'hFFFF_FFFF); end
    $display("negative: word %h", M_AXIS_tdata);
    repeat (N) step(1, 32'h2000, 1, 0, 1);
    n_cmp++; if (M_AXIS_tdata !== 32'hFFFF_E000) begin n_bad++; $display("FAIL neg_min got=%h exp=%h", M_AXIS_tdata, 32'hFFFF_E000); end
    $display("negative: word %h", M_AXIS_tdata);
  endtask

  task automatic test_truncation();
    step(0, 0, 1, 1, 1);
    step(1, 1, 1, 0, 1);
    repeat (N - 1) step(1, 0, 1, 0, 1);
    n_cmp++; if (M_AXIS_tvalid !== 1'b1 || M_AXIS_tdata !== 32'h0) begin n_bad++; $display("FAIL trunc_pos got=%b/%h exp=1/%h", M_AXIS_tvalid, M_AXIS_tdata, 32'h0); end
    step(1, 32'h3FFF, 1, 0, 1);
    repeat (N - 1) step(1, 0, 1, 0, 1);
    n_cmp++; if (M_AXIS_tdata !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL trunc_floor got=%h exp=%h", M_AXIS_tdata, 32'hFFFF_FFFF); end
    $display("truncation: word %h", M_AXIS_tdata);
  endtask

  task automatic test_backpressure();
    step(0, 0, 1, 1, 1);
    repeat (2 * N) step(1, 10, 1, 0, 0);
    n_cmp++; if (M_AXIS_tvalid !== 1'b1 || M_AXIS_tdata !== 32'd10) begin n_bad++; $display("FAIL bp_hold got=%b/%h exp=1/%h", M_AXIS_tvalid, M_AXIS_tdata, 32'd10); end
    n_cmp++; if (overrun !== 1'b1 || overrun_cnt !== 4'd1) begin n_bad++; $display("FAIL bp_overrun got=%b/%0d exp=1/1", overrun, overrun_cnt); end
    step(0, 0, 1, 0, 1);
    n_cmp++; if (M_AXIS_tvalid !== 1'b0) begin n_bad++; $display("FAIL bp_transfer got=%b exp=0", M_AXIS_tvalid); end
    n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL bp_sticky got=%b exp=1", overrun); end
    step(0, 0, 1, 1, 1);
    n_cmp++; if (overrun !== 1'b0 || overrun_cnt !== 4'd0) begin n_bad++; $display("FAIL bp_clear got=%b/%0d exp=0/0", overrun, overrun_cnt); end
    $display("backpressure: one word dropped, then cleared");
  endtask

  task automatic test_back_to_back();
    step(0, 0, 1, 1, 1);
    repeat (N) step(1, 3, 1, 0, 0);
    repeat (N - 1) step(1, 9, 1, 0, 0);
    step(1, 9, 1, 0, 1);
    n_cmp++; if (M_AXIS_tvalid !== 1'b1 || M_AXIS_tdata !== 32'd9) begin n_bad++; $display("FAIL b2b_reload got=%b/%h exp=1/%h", M_AXIS_tvalid, M_AXIS_tdata, 32'd9); end
    n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL b2b_no_overrun got=%b exp=0", overrun); end
    $display("back_to_back: word %h", M_AXIS_tdata);
  endtask

  task automatic test_saturation();
    step(0, 0, 1, 1, 1);
    repeat (N) step(1, 21, 1, 0, 0);
    repeat (20 * N) step(1, 33, 1, 0, 0);
    n_cmp++; if (overrun_cnt !== 4'hF) begin n_bad++; $display("FAIL sat_cnt got=%0d exp=15", overrun_cnt); end
    n_cmp++; if (M_AXIS_tdata !== 32'd21) begin n_bad++; $display("FAIL sat_kept got=%h exp=%h", M_AXIS_tdata, 32'd21); end
    step(0, 0, 1, 1, 1);
    n_cmp++; if (overrun_cnt !== 4'h0 || M_AXIS_tvalid !== 1'b0) begin n_bad++; $display("FAIL sat_clear got=%0d/%b exp=0/0", overrun_cnt, M_AXIS_tvalid); end
    $display("saturation: counter held at maximum");
  endtask

  task automatic test_pause_clear();
    step(0, 0, 1, 1, 1);
    step(1, 4, 1, 0, 1);
    step(1, 4, 1, 0, 1);
    repeat (5) step(1, 1000, 0, 0, 1);
    n_cmp++; if (M_AXIS_tvalid !== 1'b0) begin n_bad++; $display("FAIL pause_early got=%b exp=0", M_AXIS_tvalid); end
    step(1, 4, 1, 0, 1);
    step(1, 4, 1, 0, 1);
    n_cmp++; if (M_AXIS_tvalid !== 1'b1 || M_AXIS_tdata !== 32'd4) begin n_bad++; $display("FAIL pause_data got=%b/%h exp=1/%h", M_AXIS_tvalid, M_AXIS_tdata, 32'd4); end
    $display("pause: word %h", M_AXIS_tdata);
    step(1, 4, 1, 0, 1);
    step(1, 4, 1, 0, 1);
    step(1, 100, 1, 1, 1);
    repeat (N) step(1, 8, 1, 0, 1);
    n_cmp++; if (M_AXIS_tvalid !== 1'b1 || M_AXIS_tdata !== 32'd8) begin n_bad++; $display("FAIL clear_data got=%b/%h exp=1/%h", M_AXIS_tvalid, M_AXIS_tdata, 32'd8); end
    $display("clear: word %h", M_AXIS_tdata);
  endtask

  task automatic test_async_reset();
    step(0, 0, 1, 1, 1);
    repeat (N) step(1, 5, 1, 0, 0);
    step(1, 7, 1, 0, 0);
    step(1, 7, 1, 0, 0);
    n_cmp++; if (M_AXIS_tvalid !== 1'b1) begin n_bad++; $display("FAIL arst_pending got=%b exp=1", M_AXIS_tvalid); end
    #3 rst = 1'b1;
    #1;
    n_cmp++; if (M_AXIS_tvalid !== 1'b0 || M_AXIS_tdata !== 32'h0) begin n_bad++; $display("FAIL arst_immediate got=%b/%h exp=0/%h", M_AXIS_tvalid, M_AXIS_tdata, 32'h0); end
    #1 rst = 1'b0;
    model_reset();
    repeat (N) step(1, 2, 1, 0, 1);
    n_cmp++; if (M_AXIS_tvalid !== 1'b1 || M_AXIS_tdata !== 32'd2) begin n_bad++; $display("FAIL arst_fresh got=%b/%h exp=1/%h", M_AXIS_tvalid, M_AXIS_tdata, 32'd2); end
    $display("async_reset: word %h", M_AXIS_tdata);
  endtask

  task automatic test_random();
    bit          tv, e, c, r;
    logic [31:0] d;
    int          bad0;
    bad0 = n_bad;
    for (int i = 0; i < 600; i++) begin
      tv = ($urandom_range(0, 3) != 0);
      e  = ($urandom_range(0, 7) != 0);
      c  = ($urandom_range(0, 63) == 0);
      r  = ($urandom_range(0, 2) != 0);
      d  = $urandom;
      step(tv, d, e, c, r);
      n_cmp++; if (M_AXIS_tvalid !== m_valid) begin n_bad++; $display("FAIL rand_valid cyc=%0d got=%b exp=%b", i, M_AXIS_tvalid, m_valid); end
      if (m_valid) begin
        n_cmp++; if (M_AXIS_tdata !== m_data) begin n_bad++; $display("FAIL rand_data cyc=%0d got=%h exp=%h", i, M_AXIS_tdata, m_data); end
      end
      n_cmp++; if (overrun !== m_ovr || int'(overrun_cnt) != m_cnt) begin n_bad++; $display("FAIL rand_overrun cyc=%0d got=%b/%0d exp=%b/%0d", i, overrun, overrun_cnt, m_ovr, m_cnt); end
    end
    $display("random: 600 cycles, %0d new failures", n_bad - bad0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_truncation();
    test_backpressure();
    test_back_to_back();
    test_saturation();
    test_pause_clear();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
